// File: rtl/square_pkg.sv
// Shared constants and state encoding for the square rasteriser.
package square_pkg;
  localparam int COORD_W  = 11;
  localparam int SQ_SIZE  = 20;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } draw_state_t;
endpackage

// File: rtl/square_scan_counter.sv
// Row-major col/row scan over a SIZE x SIZE square; last flags the final pixel.
module square_scan_counter
  import square_pkg::*;
#(
  parameter int SIZE  = SQ_SIZE,
  parameter int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(SIZE - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == MAX) begin
        col <= '0;
        row <= (row == MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (col == MAX) && (row == MAX);

endmodule

// File: rtl/square_drawer.sv
// Erases the previous square then draws the new one, one pixel write per cycle,
// clipping writes that fall outside the visible screen.
module square_drawer
  import square_pkg::*;
#(
  parameter int SIZE     = SQ_SIZE,
  parameter int SCREEN_W = square_pkg::SCREEN_W,
  parameter int SCREEN_H = square_pkg::SCREEN_H
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x_loc,
  input  logic [COORD_W-1:0] y_loc,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_color,
  output logic               pix_we,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  draw_state_t        state_reg;
  logic               have_prev_reg;
  logic [COORD_W-1:0] old_x_reg, old_y_reg;
  logic [COORD_W-1:0] new_x_reg, new_y_reg;

  logic [CNT_W-1:0]   col, row;
  logic               last;
  logic               scanning;
  logic [COORD_W-1:0] base_x, base_y;
  logic [COORD_W-1:0] sum_x, sum_y;

  assign scanning = (state_reg == ERASE) || (state_reg == DRAW);

  // Counters are held at zero outside a pass, so every pass starts at (0,0).
  square_scan_counter #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_scan (
    .clk   (clk),
    .reset (reset),
    .clear (!scanning),
    .en    (scanning),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      have_prev_reg <= 1'b0;
      old_x_reg     <= '0;
      old_y_reg     <= '0;
      new_x_reg     <= '0;
      new_y_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            new_x_reg <= x_loc;
            new_y_reg <= y_loc;
            state_reg <= have_prev_reg ? ERASE : DRAW;
          end
        end
        ERASE: begin
          if (last) state_reg <= DRAW;
        end
        DRAW: begin
          if (last) begin
            state_reg     <= DONE;
            old_x_reg     <= new_x_reg;
            old_y_reg     <= new_y_reg;
            have_prev_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign base_x = (state_reg == ERASE) ? old_x_reg : new_x_reg;
  assign base_y = (state_reg == ERASE) ? old_y_reg : new_y_reg;
  assign sum_x  = base_x + COORD_W'(col);
  assign sum_y  = base_y + COORD_W'(row);

  assign pix_x     = scanning ? sum_x : '0;
  assign pix_y     = scanning ? sum_y : '0;
  assign pix_color = (state_reg == DRAW);
  assign pix_we    = scanning && (sum_x < COORD_W'(SCREEN_W)) && (sum_y < COORD_W'(SCREEN_H));
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);

endmodule

// File: tb/tb_square_drawer.sv
// Directed bench for square_drawer: pixel sequence, clipping, erase, reset and back-to-back starts.
module tb_square_drawer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] x_loc, y_loc;
  logic [10:0] pix_x, pix_y;
  logic        pix_color, pix_we, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  square_drawer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_loc     (x_loc),
    .y_loc     (y_loc),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .pix_we    (pix_we),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // One start; every cycle is compared with a row-major model of the expected pass.
  task automatic run_pass(input string tag, input int nx, input int ny,
                          input bit prev, input int ox, input int oy,
                          input int exp_writes, input int exp_done, input int inj);
    int total, writes, bad, done_cnt, done_cyc;
    int idx, bx, by, ex, ey, ec, ewe;
    total = prev ? 800 : 400;
    writes = 0; bad = 0; done_cnt = 0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; x_loc = 11'(nx); y_loc = 11'(ny);
    @(posedge clk);
    #1;
    start = 1'b0; x_loc = 11'd5; y_loc = 11'd7;
    for (int k = 1; k <= total + 3; k++) begin
      @(negedge clk);
      if (k <= total) begin
        idx = (k - 1) % 400;
        if (prev && k <= 400) begin bx = ox; by = oy; ec = 0; end
        else begin bx = nx; by = ny; ec = 1; end
        ex = bx + idx % 20;
        ey = by + idx / 20;
        ewe = (ex < 640 && ey < 480) ? 1 : 0;
        if (pix_x !== 11'(ex) || pix_y !== 11'(ey) || pix_color !== ec[0] ||
            pix_we !== ewe[0] || busy !== 1'b1 || done !== 1'b0)
          bad++;
      end else begin
        if (pix_x !== 11'd0 || pix_y !== 11'd0 || pix_color !== 1'b0 || pix_we !== 1'b0 ||
            busy !== (k == total + 1) || done !== (k == total + 1))
          bad++;
      end
      if (pix_we === 1'b1) writes++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k == inj) begin start = 1'b1; x_loc = 11'd100; y_loc = 11'd100; end
      if (k == inj + 1) start = 1'b0;
    end
    chk({tag, "_writes"}, writes, exp_writes);
    chk({tag, "_bad_cycles"}, bad, 0);
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_done_count"}, done_cnt, 1);
  endtask

  initial begin
    int d1, d2, run, max_run, busy802;
    reset = 1'b1; start = 1'b0; x_loc = '0; y_loc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_we", int'(pix_we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pix_xy", int'({pix_x, pix_y}), 0);
    reset = 1'b0;

    run_pass("first", 50, 50, 1'b0, 0, 0, 400, 401, -1);
    run_pass("erase", 600, 400, 1'b1, 50, 50, 800, 801, -1);
    run_pass("clip", 630, 470, 1'b1, 600, 400, 500, 801, -1);
    run_pass("ignore", 200, 150, 1'b1, 630, 470, 500, 801, 600);

    // Reset in the middle of the erase of (200,150).
    @(negedge clk);
    start = 1'b1; x_loc = 11'd300; y_loc = 11'd300;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_erase_busy", int'(busy), 1);
    chk("mid_erase_color", int'(pix_color), 0);
    chk("mid_erase_x", int'(pix_x), 200 + 49 % 20);
    reset = 1'b1;
    #1;
    chk("async_rst_we", int'(pix_we), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_xy", int'({pix_x, pix_y}), 0);
    @(negedge clk);
    reset = 1'b0;

    run_pass("after_rst", 0, 0, 1'b0, 0, 0, 400, 401, -1);

    // Start held high: DONE, one IDLE cycle, then the next pass.
    @(negedge clk);
    start = 1'b1; x_loc = 11'd10; y_loc = 11'd10;
    @(posedge clk);
    d1 = -1; d2 = -1; run = 0; max_run = 0; busy802 = -1;
    for (int k = 1; k <= 1610; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        run++;
        if (run > max_run) max_run = run;
        if (run == 1) begin
          if (d1 < 0) d1 = k;
          else if (d2 < 0) d2 = k;
        end
      end else begin
        run = 0;
      end
      if (k == 802) busy802 = int'(busy);
    end
    chk("held_done1", d1, 801);
    chk("held_idle_gap", busy802, 0);
    chk("held_done2", d2, 1603);
    chk("held_done_width", max_run, 1);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/square_drawer.md
# square_drawer

Rasterises the square whose top-left corner comes from `square_loc_picker` into the VGA frame buffer. On each `start` it first erases the previously drawn square and then draws the new square. Both passes emit one pixel write per cycle in row-major order, and the block pulses `done` when finished. It sits between `square_loc_picker` (its `start` is tied to the picker's `done`) and the frame-buffer/VGA pixel-write port.

## Interface
- `SIZE`, 20, side length of the square in pixels.
- `SCREEN_W`, 640, visible width; pixels with x ≥ `SCREEN_W` are clipped.
- `SCREEN_H`, 480, visible height; pixels with y ≥ `SCREEN_H` are clipped.
- `clk` input 1: single clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request to draw at `x_loc`/`y_loc`; sampled only in IDLE.
- `x_loc` input 11: top-left x of the new square.
- `y_loc` input 11: top-left y of the new square.
- `pix_x` output 11: x coordinate of the current pixel write.
- `pix_y` output 11: y coordinate of the current pixel write.
- `pix_color` output 1: 1 draws the pixel, 0 erases it.
- `pix_we` output 1: pixel write strobe, one pixel per cycle.
- `busy` output 1: high in ERASE, DRAW and DONE.
- `done` output 1: one-cycle pulse after the last DRAW pixel.

## Operation
- FSM states and transitions:
  - IDLE: on `start`, latch `x_loc`/`y_loc` into `new_x`/`new_y` and clear `col`/`row`. Go to ERASE if `have_prev` = 1, else to DRAW.
  - ERASE: base = `old_x`/`old_y`, `pix_color` = 0. Go to DRAW when `col` = `row` = SIZE-1; `col`/`row` clear on that transition.
  - DRAW: base = `new_x`/`new_y`, `pix_color` = 1. When `col` = `row` = SIZE-1: go to DONE, copy new→old, set `have_prev` = 1.
  - DONE: `done` = 1 for this cycle only, then go to IDLE.
- Scan order: `col` increments every cycle; when it wraps at SIZE-1 it returns to 0 and `row` increments. This gives exactly SIZE² cycles per pass.
- Pixel outputs are combinational from the registered state, base and counters:
  - `pix_x` = base_x + `col`; `pix_y` = base_y + `row`.
  - Widths: 11-bit add; no overflow for inputs ≤ 2047-SIZE.
- `pix_we` = (ERASE or DRAW) and `pix_x` < SCREEN_W and `pix_y` < SCREEN_H. Clipped pixels still consume their cycle, so pass length is always SIZE².
- In IDLE and DONE: `pix_we` = 0, `pix_x` = `pix_y` = 0, `pix_color` = 0.
- `start` outside IDLE is ignored and not queued. Input changes after latching have no effect.

## Timing
- Reset values:
  - State IDLE; all outputs 0.
  - `have_prev` = 0; `old_x`, `old_y`, `new_x`, `new_y`, `col`, `row` all 0.
- Let edge E be the rising edge where `start` is sampled in IDLE.
  - First pixel write is valid in the cycle following E.
  - First draw (no erase): `done` is high in cycle SIZE²+1 after E.
  - With erase: `done` is high in cycle 2·SIZE²+1 after E.
- Back-to-back: the next `start` is accepted at the earliest on the first IDLE edge after DONE.
- Reset mid-operation: immediate return to IDLE with all outputs 0. `have_prev` is cleared, so the next `start` skips ERASE; a partial square may remain on screen.

## Structure
- Package `square_pkg` holds:
  - `SCREEN_W`, `SCREEN_H`, `SQ_SIZE` constants.
  - `draw_state_t` enum: IDLE, ERASE, DRAW, DONE.
  - `COORD_W` = 11.
- One sub-module, `square_scan_counter`, contains the `col`/`row` counters:
  - Inputs: `clk`, `reset`, `clear`, `en`.
  - Outputs: `col`, `row`, `last` (high when `col` = `row` = SIZE-1).

## Test plan
- Reset, then `start` with (50,50), SIZE=20 → no ERASE. Exactly 400 `pix_we` cycles with color 1, covering x 50..69 and y 50..69 in row-major order. First write is (50,50), last is (69,69). `done` is high in cycle 401 only.
- Then `start` with (600,400) → 400 color-0 writes over (50..69, 50..69), followed by 400 color-1 writes over (600..619, 400..419). `done` is high in cycle 801.
- `start` with (630,470) → DRAW still lasts 400 cycles. `pix_we` is asserted only for x 630..639 and y 470..479: 100 writes, the rest clipped.
- Pulse `start` with (100,100) mid-DRAW → ignored. The square completes at the latched location, and the following ERASE targets that location, not (100,100).
- Assert `reset` during ERASE → outputs 0 asynchronously, before the next edge. The next `start` with (0,0) goes straight to DRAW (400 writes), and `done` is high in cycle 401.
- Hold `start` high continuously → each DONE is followed by one IDLE cycle, then a new pass begins. `done` pulses are exactly one cycle wide.
